// File: rtl/accum_pkg.sv
// ----------------------------------------------------------------------------
// accum_pkg
// Shared types and default widths for the SpMV final reduction stage.
//   accum_tuple_t : packed {row_idx, value, valid} tuple at the default widths;
//                   valid sits in bit 0.
//   iss_case_t    : per-cycle decision of the reduction controller.
// ----------------------------------------------------------------------------
package accum_pkg;

    localparam int ACC_ROW_W   = 16;
    localparam int ACC_VAL_W   = 32;
    localparam int ACC_ADD_LAT = 3;
    localparam int ACC_Q_ASIZE = 3;
    localparam int ACC_DATA_W  = ACC_ROW_W + ACC_VAL_W + 1;

    typedef struct packed {
        logic [ACC_ROW_W-1:0] row_idx;
        logic [ACC_VAL_W-1:0] value;
        logic                 valid;
    } accum_tuple_t;

    typedef enum logic [2:0] {
        ISS_RECIRC,
        ISS_OUT_IN,
        ISS_LOAD_OUT,
        ISS_M_IN,
        ISS_LOAD_IN,
        ISS_NEWROW,
        ISS_IDLE
    } iss_case_t;

endpackage

// File: rtl/accum_reduce_stg_int_add_pipe.sv
// ----------------------------------------------------------------------------
// int_add_pipe
// ADD_LAT-deep integer adder pipeline. The sum is formed on entry and then
// shifted, so the result appears at the exit stage ADD_LAT cycles after issue.
// A floating-point adder with the same ports can be dropped in.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (clears valids only)
//   en           : advance enable; the pipe holds when low
//   in_valid/in_row/in_a/in_b : issue slot
//   out_valid/out_row/out_sum : exit stage
//   inflight     : number of valid stages, exit stage included
// ----------------------------------------------------------------------------
module int_add_pipe #(
    parameter int ROW_W   = 16,
    parameter int VAL_W   = 32,
    parameter int ADD_LAT = 3,
    parameter int CNT_W   = $clog2(ADD_LAT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [ROW_W-1:0] in_row,
    input  logic [VAL_W-1:0] in_a,
    input  logic [VAL_W-1:0] in_b,
    output logic             out_valid,
    output logic [ROW_W-1:0] out_row,
    output logic [VAL_W-1:0] out_sum,
    output logic [CNT_W-1:0] inflight
);

    logic [ADD_LAT-1:0] vld_q;
    logic [ROW_W-1:0]   row_q [ADD_LAT];
    logic [VAL_W-1:0]   sum_q [ADD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else if (en) begin
            vld_q[0] <= in_valid;
            row_q[0] <= in_row;
            sum_q[0] <= in_a + in_b;
            for (int k = 1; k < ADD_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                row_q[k] <= row_q[k-1];
                sum_q[k] <= sum_q[k-1];
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int k = 0; k < ADD_LAT; k++) begin
            inflight = inflight + CNT_W'(vld_q[k]);
        end
    end

    assign out_valid = vld_q[ADD_LAT-1];
    assign out_row   = row_q[ADD_LAT-1];
    assign out_sum   = sum_q[ADD_LAT-1];

endmodule

// File: rtl/accum_reduce_stg.sv
// ----------------------------------------------------------------------------
// accum_reduce_stg
// Final reduction stage: collapses each run of equal row_idx in a row-sorted
// {row_idx, value, valid} stream into one {row_idx, sum, 1} tuple, in order.
// Partial sums leaving the adder pipe are recirculated until one remains.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   en_global           : global freeze, no state changes while low
//   data_ended          : level, end of input; requests a flush
//   di                  : input tuple, prev_stg_rd_ready marks it presentable
//   en_stg              : di consumed this cycle
//   next_stg_rd_en      : pop the output FIFO
//   out_q_rd_ready      : output FIFO non-empty
//   do_accum_stg_out_q  : FIFO head, show-ahead (zero while empty)
//   flush_done          : one-cycle pulse when a flush completes
//
// Issue cases (first match wins, o = pipe exit valid, m = merge reg valid):
//   case          | meaning
//   ISS_RECIRC    | o & m        : M+o into pipe, input held
//   ISS_OUT_IN    | o & same row : o+di into pipe
//   ISS_LOAD_OUT  | o only       : park o in M
//   ISS_M_IN      | m & same row : M+di into pipe
//   ISS_LOAD_IN   | same row     : park di in M
//   ISS_NEWROW    | new row      : push M, start row from di (pipe idle only)
//   ISS_IDLE      | nothing issued
// ----------------------------------------------------------------------------
module accum_reduce_stg
    import accum_pkg::*;
#(
    parameter int ROW_W      = ACC_ROW_W,
    parameter int VAL_W      = ACC_VAL_W,
    parameter int ADD_LAT    = ACC_ADD_LAT,
    parameter int Q_ASIZE    = ACC_Q_ASIZE,
    parameter int DATA_WIDTH = ROW_W + VAL_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_global,
    input  logic                  data_ended,
    input  logic [DATA_WIDTH-1:0] di,
    input  logic                  prev_stg_rd_ready,
    output logic                  en_stg,
    input  logic                  next_stg_rd_en,
    output logic                  out_q_rd_ready,
    output logic [DATA_WIDTH-1:0] do_accum_stg_out_q,
    output logic                  flush_done
);

    localparam int CNT_W   = $clog2(ADD_LAT + 1);
    localparam int Q_DEPTH = 1 << Q_ASIZE;

    logic             di_valid;
    logic [VAL_W-1:0] di_value;
    logic [ROW_W-1:0] di_row;

    assign di_valid = di[0];
    assign di_value = di[VAL_W:1];
    assign di_row   = di[ROW_W+VAL_W:VAL_W+1];

    logic             o_valid;
    logic [ROW_W-1:0] o_row;
    logic [VAL_W-1:0] o_sum;
    logic [CNT_W-1:0] inflight;

    logic             m_valid;
    logic [ROW_W-1:0] m_row;
    logic [VAL_W-1:0] m_value;
    logic [ROW_W-1:0] cur_row;
    logic             cur_row_valid;

    logic [DATA_WIDTH-1:0] q_mem [Q_DEPTH];
    logic [Q_ASIZE:0]      wr_ptr;
    logic [Q_ASIZE:0]      rd_ptr;
    logic                  q_full;
    logic                  q_empty;
    logic                  q_pop;

    logic flush_armed;

    iss_case_t             iss;
    logic                  iss_valid;
    logic [ROW_W-1:0]      iss_row;
    logic [VAL_W-1:0]      iss_a;
    logic [VAL_W-1:0]      iss_b;
    logic                  accept_in;
    logic                  q_push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  flush_fire;
    logic                  in_tok;
    logic                  in_bub;
    logic                  in_hit;
    logic                  in_new;
    logic                  pipe_idle;

    assign in_tok    = prev_stg_rd_ready & di_valid;
    assign in_bub    = prev_stg_rd_ready & ~di_valid;
    assign in_hit    = in_tok & cur_row_valid & (di_row == cur_row);
    assign in_new    = in_tok & ~in_hit;
    assign pipe_idle = (inflight == '0);

    assign q_empty = (wr_ptr == rd_ptr);
    assign q_full  = (wr_ptr[Q_ASIZE] != rd_ptr[Q_ASIZE]) &&
                     (wr_ptr[Q_ASIZE-1:0] == rd_ptr[Q_ASIZE-1:0]);
    assign q_pop   = next_stg_rd_en & ~q_empty;

    always_comb begin
        iss        = ISS_IDLE;
        iss_valid  = 1'b0;
        iss_row    = m_row;
        iss_a      = m_value;
        iss_b      = o_sum;
        accept_in  = 1'b0;
        q_push     = 1'b0;
        push_data  = {m_row, m_value, 1'b1};
        flush_fire = 1'b0;

        if (o_valid && m_valid) begin
            iss       = ISS_RECIRC;
            iss_valid = 1'b1;
        end else if (o_valid && in_hit) begin
            iss       = ISS_OUT_IN;
            iss_valid = 1'b1;
            iss_row   = o_row;
            iss_a     = o_sum;
            iss_b     = di_value;
            accept_in = 1'b1;
        end else if (o_valid) begin
            iss = ISS_LOAD_OUT;
        end else if (m_valid && in_hit) begin
            iss       = ISS_M_IN;
            iss_valid = 1'b1;
            iss_b     = di_value;
            accept_in = 1'b1;
        end else if (in_hit) begin
            iss       = ISS_LOAD_IN;
            accept_in = 1'b1;
        end else if (in_new && pipe_idle && !q_full) begin
            // Pipe must be empty so the old row's sum is final before pushing.
            iss       = ISS_NEWROW;
            accept_in = 1'b1;
            q_push    = m_valid;
        end

        // Flush never overlaps a new-row push: it requires no valid input.
        flush_fire = data_ended && flush_armed && !in_tok && pipe_idle &&
                     (!m_valid || !q_full);
        if (flush_fire && m_valid) begin
            q_push = 1'b1;
        end
    end

    assign en_stg = en_global & ~rst &
                    (accept_in | (in_bub & (iss != ISS_RECIRC)));

    int_add_pipe #(
        .ROW_W   (ROW_W),
        .VAL_W   (VAL_W),
        .ADD_LAT (ADD_LAT),
        .CNT_W   (CNT_W)
    ) u_add_pipe (
        .clk       (clk),
        .rst       (rst),
        .en        (en_global),
        .in_valid  (iss_valid),
        .in_row    (iss_row),
        .in_a      (iss_a),
        .in_b      (iss_b),
        .out_valid (o_valid),
        .out_row   (o_row),
        .out_sum   (o_sum),
        .inflight  (inflight)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid       <= 1'b0;
            cur_row_valid <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            flush_done    <= 1'b0;
            flush_armed   <= 1'b1;
        end else if (en_global) begin
            flush_done <= flush_fire;
            if (!data_ended) begin
                flush_armed <= 1'b1;
            end else if (flush_fire) begin
                flush_armed <= 1'b0;
            end

            case (iss)
                ISS_RECIRC, ISS_M_IN: begin
                    m_valid <= 1'b0;
                end
                ISS_LOAD_OUT: begin
                    m_valid <= 1'b1;
                    m_row   <= o_row;
                    m_value <= o_sum;
                end
                ISS_LOAD_IN: begin
                    m_valid <= 1'b1;
                    m_row   <= di_row;
                    m_value <= di_value;
                end
                ISS_NEWROW: begin
                    m_valid       <= 1'b1;
                    m_row         <= di_row;
                    m_value       <= di_value;
                    cur_row       <= di_row;
                    cur_row_valid <= 1'b1;
                end
                default: ;
            endcase

            if (flush_fire) begin
                m_valid       <= 1'b0;
                cur_row_valid <= 1'b0;
            end

            if (q_push) begin
                q_mem[wr_ptr[Q_ASIZE-1:0]] <= push_data;
                wr_ptr                     <= wr_ptr + 1'b1;
            end
            if (q_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign out_q_rd_ready     = ~q_empty;
    assign do_accum_stg_out_q = q_empty ? '0 : q_mem[rd_ptr[Q_ASIZE-1:0]];

endmodule

// File: tb/tb_accum_reduce_stg.sv
module tb_accum_reduce_stg;

    localparam int ROW_W   = 16;
    localparam int VAL_W   = 8;
    localparam int ADD_LAT = 3;
    localparam int Q_ASIZE = 2;
    localparam int DW      = ROW_W + VAL_W + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en_global;
    logic          data_ended;
    logic [DW-1:0] di;
    logic          prev_stg_rd_ready;
    logic          en_stg;
    logic          next_stg_rd_en;
    logic          out_q_rd_ready;
    logic [DW-1:0] dout;
    logic          flush_done;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] exp_q [$];

    accum_reduce_stg #(
        .ROW_W      (ROW_W),
        .VAL_W      (VAL_W),
        .ADD_LAT    (ADD_LAT),
        .Q_ASIZE    (Q_ASIZE),
        .DATA_WIDTH (DW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .en_global          (en_global),
        .data_ended         (data_ended),
        .di                 (di),
        .prev_stg_rd_ready  (prev_stg_rd_ready),
        .en_stg             (en_stg),
        .next_stg_rd_en     (next_stg_rd_en),
        .out_q_rd_ready     (out_q_rd_ready),
        .do_accum_stg_out_q (dout),
        .flush_done         (flush_done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] tup(input int row, input int val, input logic v);
        logic [ROW_W-1:0] r;
        logic [VAL_W-1:0] x;
        r = ROW_W'(row);
        x = VAL_W'(val);
        return {r, x, v};
    endfunction

    // Scoreboard: every pop the DUT performs is compared with the queue head.
    always @(negedge clk) begin
        if (!rst && en_global && next_stg_rd_en && out_q_rd_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL pop_unexpected got=%h required none", dout);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (dout !== e) $display("FAIL pop_data got=%h required %h", dout, e);
                else n_pass++;
            end
        end
    end

    task automatic send(input int row, input int val, input logic v);
        int t;
        bit done;
        di = tup(row, val, v);
        prev_stg_rd_ready = 1'b1;
        t = 0;
        done = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            if (en_stg) done = 1;
            t++;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL send_timeout row=%0d en_stg=%b required 1", row, en_stg);
        end
        @(posedge clk); #1;
        prev_stg_rd_ready = 1'b0;
    endtask

    task automatic run_flush(output int pulses);
        pulses = 0;
        data_ended = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (flush_done) pulses++;
        end
        @(posedge clk); #1;
        data_ended = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_q_rd_ready) && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (en_stg !== 1'b0) $display("FAIL reset_en_stg got=%b required 0", en_stg); else n_pass++;
        n_checks++; if (out_q_rd_ready !== 1'b0) $display("FAIL reset_rd_ready got=%b required 0", out_q_rd_ready); else n_pass++;
        n_checks++; if (flush_done !== 1'b0) $display("FAIL reset_flush_done got=%b required 0", flush_done); else n_pass++;
        n_checks++; if (dout !== '0) $display("FAIL reset_dout got=%h required 0", dout); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int p;
        exp_q.push_back(tup(5, 1 + 2 + 3 + 4, 1'b1));
        exp_q.push_back(tup(9, 10, 1'b1));
        for (int k = 1; k <= 4; k++) send(5, k, 1'b1);
        send(9, 10, 1'b1);
        run_flush(p);
        n_checks++; if (p !== 1) $display("FAIL basic_flush_pulses got=%0d required 1", p); else n_pass++;
        drain();
        n_checks++; if (exp_q.size() !== 0) $display("FAIL basic_outputs_missing got=%0d required 0", exp_q.size()); else n_pass++;
        n_checks++; if (out_q_rd_ready !== 1'b0) $display("FAIL basic_fifo_empty got=%b required 0", out_q_rd_ready); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int p;
        for (int k = 0; k < 3; k++) exp_q.push_back(tup(k + 1, k + 7, 1'b1));
        send(1, 7, 1'b1);
        send(0, 0, 1'b0);
        send(2, 8, 1'b1);
        send(3, 9, 1'b1);
        run_flush(p);
        n_checks++; if (p !== 1) $display("FAIL b2b_flush_pulses got=%0d required 1", p); else n_pass++;
        drain();
        n_checks++; if (exp_q.size() !== 0) $display("FAIL b2b_outputs_missing got=%0d required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_wrap();
        int p;
        exp_q.push_back(tup(4, (200 + 100) % 256, 1'b1));
        send(4, 200, 1'b1);
        send(4, 100, 1'b1);
        run_flush(p);
        n_checks++; if (p !== 1) $display("FAIL wrap_flush_pulses got=%0d required 1", p); else n_pass++;
        drain();
        n_checks++; if (exp_q.size() !== 0) $display("FAIL wrap_outputs_missing got=%0d required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_full();
        int p;
        int seen;
        next_stg_rd_en = 1'b0;
        for (int k = 0; k < 6; k++) exp_q.push_back(tup(10 + k, k + 1, 1'b1));
        for (int k = 0; k < 5; k++) send(10 + k, k + 1, 1'b1);
        repeat (2) @(negedge clk);
        n_checks++; if (out_q_rd_ready !== 1'b1) $display("FAIL full_rd_ready got=%b required 1", out_q_rd_ready); else n_pass++;
        n_checks++; if (dout !== tup(10, 1, 1'b1)) $display("FAIL full_head got=%h required %h", dout, tup(10, 1, 1'b1)); else n_pass++;
        di = tup(15, 6, 1'b1);
        prev_stg_rd_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (en_stg) seen++;
        end
        n_checks++; if (seen !== 0) $display("FAIL full_stall en_stg_cycles=%0d required 0", seen); else n_pass++;
        @(posedge clk); #1;
        next_stg_rd_en = 1'b1;
        send(15, 6, 1'b1);
        run_flush(p);
        n_checks++; if (p !== 1) $display("FAIL full_flush_pulses got=%0d required 1", p); else n_pass++;
        drain();
        n_checks++; if (exp_q.size() !== 0) $display("FAIL full_outputs_missing got=%0d required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_freeze();
        int p;
        int seen;
        exp_q.push_back(tup(3, 20, 1'b1));
        for (int k = 0; k < 20; k++) begin
            if (k == 10) begin
                en_global = 1'b0;
                di = tup(3, 1, 1'b1);
                prev_stg_rd_ready = 1'b1;
                seen = 0;
                repeat (5) begin
                    @(negedge clk);
                    if (en_stg) seen++;
                end
                @(posedge clk); #1;
                en_global = 1'b1;
                n_checks++; if (seen !== 0) $display("FAIL freeze_en_stg cycles=%0d required 0", seen); else n_pass++;
            end
            send(3, 1, 1'b1);
        end
        run_flush(p);
        n_checks++; if (p !== 1) $display("FAIL freeze_flush_pulses got=%0d required 1", p); else n_pass++;
        drain();
        n_checks++; if (exp_q.size() !== 0) $display("FAIL freeze_outputs_missing got=%0d required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int p;
        for (int k = 1; k <= 6; k++) send(7, k, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (out_q_rd_ready !== 1'b0) $display("FAIL rstmid_rd_ready got=%b required 0", out_q_rd_ready); else n_pass++;
        n_checks++; if (dout !== '0) $display("FAIL rstmid_dout got=%h required 0", dout); else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++; if (out_q_rd_ready !== 1'b0) $display("FAIL rstmid_no_row7 got=%b required 0", out_q_rd_ready); else n_pass++;
        @(posedge clk); #1;
        exp_q.push_back(tup(8, 5, 1'b1));
        send(8, 5, 1'b1);
        run_flush(p);
        n_checks++; if (p !== 1) $display("FAIL rstmid_flush_pulses got=%0d required 1", p); else n_pass++;
        drain();
        n_checks++; if (exp_q.size() !== 0) $display("FAIL rstmid_outputs_missing got=%0d required 0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        rst               = 1'b1;
        en_global         = 1'b1;
        data_ended        = 1'b0;
        di                = '0;
        prev_stg_rd_ready = 1'b0;
        next_stg_rd_en    = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_wrap();
        test_full();
        test_freeze();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
